// File: rtl/vce_pkg.sv
// vce_pkg: shared types and constants for the VCE colour RAM arbiter.
//   gnt_t      - per-cycle owner of the single RAM port
//   rd_state_t - CPU read sequencing states
//   CRAM_ADDR_W / CRAM_DATA_W - colour RAM geometry (512 x 9, GRB 3:3:3)
package vce_pkg;

  localparam int CRAM_ADDR_W = 9;
  localparam int CRAM_DATA_W = 9;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIX  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } gnt_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cram_wfifo.sv
// cram_wfifo: small synchronous FIFO holding posted CPU colour-table writes.
// Ports:
//   clock, reset_N       - clock, asynchronous active-low reset
//   push, push_data      - enqueue request and entry (ignored when full)
//   pop                  - dequeue request (ignored when empty)
//   head_data            - oldest entry, combinational from storage
//   full, empty, count   - occupancy, all derived from the registered count
// DEPTH must be a power of two (pointers wrap by natural overflow), minimum 2.
module cram_wfifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 18,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer / count registers.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so a stale head never reaches the RAM.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cram_arbiter.sv
// cram_arbiter: shares one single-port 512x9 colour RAM between the pixel
// fetch path and the CPU colour-table interface.
// Ports:
//   clock, reset_N                    - clock, asynchronous active-low reset
//   pix_req/pix_addr -> pix_data/pix_valid    - pixel fetch, data at t+1
//   cpu_wr_req/addr/data, cpu_wr_ready        - posted writes into a FIFO
//   cpu_rd_req/addr -> cpu_rd_data/valid/busy - reads ordered behind writes
//   wr_overflow                       - sticky: write dropped on full FIFO
//   ram_addr/ram_wdata/ram_we, ram_rdata      - RAM port, 1-cycle read
// Build option: define CRAM_ARTIFACT_EN to give CPU accesses priority over
// the pixel fetch; a losing pixel then shows the CPU word (palette speckle).
module cram_arbiter
  import vce_pkg::*;
#(
  parameter int ADDR_W      = CRAM_ADDR_W,
  parameter int DATA_W      = CRAM_DATA_W,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic              cpu_rd_busy,
  output logic              wr_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(WFIFO_DEPTH + 1);

  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [ENTRY_W-1:0] fifo_head_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [DATA_W-1:0]  head_data_s;

  gnt_t               gnt_d, gnt_q;
  rd_state_t          rd_state_d, rd_state_q;
  logic [ADDR_W-1:0]  rd_addr_d, rd_addr_q;
  logic [DATA_W-1:0]  pix_data_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               wr_overflow_d, wr_overflow_q;
  logic [DATA_W-1:0]  pix_word_s;

  // Ready comes from the registered count, so a full FIFO never sees a
  // same-cycle enqueue even if it is also being drained.
  assign cpu_wr_ready = (fifo_count_s < CNT_W'(WFIFO_DEPTH));
  assign fifo_push_s  = cpu_wr_req & cpu_wr_ready;
  assign fifo_pop_s   = (gnt_d == GNT_WR);
  assign head_addr_s  = fifo_head_s[ENTRY_W-1:DATA_W];
  assign head_data_s  = fifo_head_s[DATA_W-1:0];

  cram_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wfifo (
    .clock     (clock),
    .reset_N   (reset_N),
    .push      (fifo_push_s),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (fifo_pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Per-cycle RAM port owner.
  always_comb begin
    gnt_d = GNT_NONE;
`ifdef CRAM_ARTIFACT_EN
    if (!fifo_empty_s) begin
      gnt_d = GNT_WR;
    end else if (rd_state_q == RD_WAIT) begin
      gnt_d = GNT_RD;
    end else if (pix_req) begin
      gnt_d = GNT_PIX;
    end else begin
      gnt_d = GNT_NONE;
    end
`else
    if (pix_req) begin
      gnt_d = GNT_PIX;
    end else if (!fifo_empty_s) begin
      gnt_d = GNT_WR;
    end else if (rd_state_q == RD_WAIT) begin
      gnt_d = GNT_RD;
    end else begin
      gnt_d = GNT_NONE;
    end
`endif
  end

  // RAM port drive from the granted source.
  always_comb begin
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    ram_we    = 1'b0;
    case (gnt_d)
      GNT_PIX: ram_addr = pix_addr;
      GNT_WR: begin
        ram_addr  = head_addr_s;
        ram_wdata = head_data_s;
        ram_we    = 1'b1;
      end
      GNT_RD:  ram_addr = rd_addr_q;
      default: ram_addr = {ADDR_W{1'b0}};
    endcase
  end

  // Read sequencer next-state; a request while busy is ignored.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (cpu_rd_req) begin
          rd_state_d = RD_WAIT;
          rd_addr_d  = cpu_rd_addr;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (gnt_d == GNT_RD) begin
          rd_state_d = RD_DATA;
        end else begin
          rd_state_d = RD_WAIT;
        end
      end
      RD_DATA: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign wr_overflow_d = wr_overflow_q | (cpu_wr_req & fifo_full_s);

`ifdef CRAM_ARTIFACT_EN
  logic              pix_req_q;
  logic [DATA_W-1:0] wr_word_q;

  // Remember the pixel request and the CPU write word of the previous cycle.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pix_req_q <= 1'b0;
      wr_word_q <= {DATA_W{1'b0}};
    end else begin
      pix_req_q <= pix_req;
      wr_word_q <= ram_wdata;
    end
  end

  // A pixel that lost the port shows whatever word the CPU moved that cycle.
  assign pix_valid  = pix_req_q;
  assign pix_word_s = (gnt_q == GNT_WR) ? wr_word_q : ram_rdata;
`else
  assign pix_valid  = (gnt_q == GNT_PIX);
  assign pix_word_s = ram_rdata;
`endif

  // RAM read data is only live in the cycle after the access; the held
  // copies keep the outputs stable until the next response.
  assign pix_data     = pix_valid ? pix_word_s : pix_data_q;
  assign cpu_rd_valid = (gnt_q == GNT_RD);
  assign cpu_rd_data  = cpu_rd_valid ? ram_rdata : rd_data_q;
  assign cpu_rd_busy  = (rd_state_q != RD_IDLE);
  assign wr_overflow  = wr_overflow_q;

  // Grant pipeline, read sequencer, held responses and overflow flag.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      gnt_q         <= GNT_NONE;
      rd_state_q    <= RD_IDLE;
      rd_addr_q     <= {ADDR_W{1'b0}};
      pix_data_q    <= {DATA_W{1'b0}};
      rd_data_q     <= {DATA_W{1'b0}};
      wr_overflow_q <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      wr_overflow_q <= wr_overflow_d;
      if (pix_valid) begin
        pix_data_q <= pix_word_s;
      end
      if (cpu_rd_valid) begin
        rd_data_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cram_arbiter.sv
`timescale 1ns/1ps
module tb_cram_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 9;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset_N;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_ready;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_valid;
  logic          cpu_rd_busy;
  logic          wr_overflow;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          preload;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_N      (reset_N),
    .pix_req      (pix_req),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_busy  (cpu_rd_busy),
    .wr_overflow  (wr_overflow),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata)
  );

  // Initial colour RAM contents; address 0x012 holds 0x1A5.
  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i * 37 + 11);
    if (i == 18) v = 9'h1A5;
    return v;
  endfunction

  // Single-port RAM with registered read data.
  logic [DW-1:0] ram_mem [512];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= init_val(i);
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]      ref_mem [512];
  logic [AW+DW-1:0]   wq [$];     // posted writes {addr,data}, oldest first
  int                 rd_phase;   // 0 idle, 1 waiting for port, 2 data cycle
  logic [AW-1:0]      rd_addr_m;
  logic               exp_pv, exp_rv, exp_ovf;
  logic [DW-1:0]      exp_pd, exp_rd;
  bit                 pix_prev;

  task automatic model_clear();
    wq.delete();
    rd_phase = 0;
    rd_addr_m = '0;
    exp_pv = 1'b0; exp_rv = 1'b0; exp_ovf = 1'b0;
    exp_pd = '0;   exp_rd = '0;
    pix_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic do_cycle(input bit pr, input logic [AW-1:0] pa,
                          input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit rr, input logic [AW-1:0] ra);
    int            who;      // 0 none, 1 pixel, 2 write, 3 read
    bit            ready;
    logic [AW-1:0] e_addr;
    pix_req = pr; pix_addr = pa;
    cpu_wr_req = wr; cpu_wr_addr = wa; cpu_wr_data = wd;
    cpu_rd_req = rr; cpu_rd_addr = ra;
    @(negedge clock);
    ready = (wq.size() < DEPTH);
`ifdef CRAM_ARTIFACT_EN
    who = (wq.size() > 0) ? 2 : (rd_phase == 1) ? 3 : pr ? 1 : 0;
`else
    who = pr ? 1 : (wq.size() > 0) ? 2 : (rd_phase == 1) ? 3 : 0;
`endif
    check_val("pix_valid", pix_valid, exp_pv);
    check_val("pix_data", pix_data, exp_pd);
    check_val("rd_valid", cpu_rd_valid, exp_rv);
    check_val("rd_data", cpu_rd_data, exp_rd);
    check_val("rd_busy", cpu_rd_busy, rd_phase != 0);
    check_val("wr_ready", cpu_wr_ready, ready);
    check_val("wr_overflow", wr_overflow, exp_ovf);
    check_val("ram_we", ram_we, who == 2);
    e_addr = (who == 1) ? pa : (who == 2) ? wq[0][AW+DW-1:DW] : (who == 3) ? rd_addr_m : '0;
    check_val("ram_addr", ram_addr, e_addr);
    if (who == 2) check_val("ram_wdata", ram_wdata, wq[0][DW-1:0]);
    // responses visible next cycle
    exp_pv = pr;
    if (pr) exp_pd = (who == 2) ? wq[0][DW-1:0] : (who == 3) ? ref_mem[rd_addr_m] : ref_mem[pa];
    exp_rv = (who == 3);
    if (who == 3) exp_rd = ref_mem[rd_addr_m];
    if (who == 2) begin
      ref_mem[wq[0][AW+DW-1:DW]] = wq[0][DW-1:0];
      void'(wq.pop_front());
    end
    if (wr) begin
      if (ready) wq.push_back({wa, wd});
      else exp_ovf = 1'b1;
    end
    case (rd_phase)
      0: if (rr) begin rd_phase = 1; rd_addr_m = ra; end
      1: if (who == 3) rd_phase = 2;
      default: rd_phase = 0;
    endcase
    pix_prev = pr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_pix_valid"}, pix_valid, 1'b0);
    check_val({tag, "_pix_data"}, pix_data, 9'h000);
    check_val({tag, "_rd_valid"}, cpu_rd_valid, 1'b0);
    check_val({tag, "_rd_data"}, cpu_rd_data, 9'h000);
    check_val({tag, "_rd_busy"}, cpu_rd_busy, 1'b0);
    check_val({tag, "_wr_ready"}, cpu_wr_ready, 1'b1);
    check_val({tag, "_ovf"}, wr_overflow, 1'b0);
    check_val({tag, "_ram_we"}, ram_we, 1'b0);
    check_val({tag, "_ram_addr"}, ram_addr, 9'h000);
  endtask

  initial begin
    reset_N = 1'b0; preload = 1'b1;
    pix_req = 1'b0; pix_addr = '0;
    cpu_wr_req = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 1'b0; cpu_rd_addr = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    model_clear();
    @(posedge clock); #1;
    preload = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    @(posedge clock); #2;
    reset_N = 1'b1;
    @(posedge clock); #1;

    // Pixel latency: data and valid one cycle after the request.
    do_cycle(1'b1, 9'h012, 1'b0, '0, '0, 1'b0, '0);
    check_val("pix_lat_valid", pix_valid, 1'b1);
    check_val("pix_lat_data", pix_data, 9'h1A5);
    idle(2);

    // Write drain with pixel fetches in every second cycle.
    do_cycle(1'b1, 9'h001, 1'b1, 9'h010, 9'h001, 1'b0, '0);
    do_cycle(1'b0, 9'h000, 1'b1, 9'h011, 9'h002, 1'b0, '0);
    do_cycle(1'b1, 9'h002, 1'b1, 9'h012, 9'h003, 1'b0, '0);
    do_cycle(1'b0, 9'h000, 1'b0, '0, '0, 1'b0, '0);
    do_cycle(1'b1, 9'h003, 1'b0, '0, '0, 1'b0, '0);
    do_cycle(1'b0, 9'h000, 1'b0, '0, '0, 1'b0, '0);
    do_cycle(1'b1, 9'h012, 1'b0, '0, '0, 1'b0, '0);
    check_val("drain_pix_data", pix_data, 9'h003);
    idle(2);

    // Ordering: write and read to the same address in one cycle.
    do_cycle(1'b0, '0, 1'b1, 9'h100, 9'h155, 1'b1, 9'h100);
    for (int k = 0; k < 2 * DEPTH + 3 && cpu_rd_busy; k++) idle(1);
    check_val("ord_done", cpu_rd_busy, 1'b0);
    check_val("ord_rd_data", cpu_rd_data, 9'h155);
    idle(2);

    // Overflow: back-to-back writes while pixels take every second cycle.
    for (int k = 0; k < 9; k++)
      do_cycle(k % 2 == 0, 9'(k), 1'b1, 9'h080 + 9'(k), 9'h040 + 9'(k), 1'b0, '0);
    idle(10);
    check_val("ovf_sticky", wr_overflow, 1'b1);

    // Pixel colliding with a queued write (artifact build shows the write word).
    do_cycle(1'b0, '0, 1'b1, 9'h040, 9'h0C3, 1'b0, '0);
    do_cycle(1'b1, 9'h040, 1'b0, '0, '0, 1'b0, '0);
    idle(3);

    // Reset with two writes queued and a read waiting for the port.
    do_cycle(1'b1, 9'h005, 1'b1, 9'h0A0, 9'h111, 1'b0, '0);
    do_cycle(1'b0, 9'h000, 1'b1, 9'h0A1, 9'h122, 1'b1, 9'h0A0);
    do_cycle(1'b1, 9'h006, 1'b1, 9'h0A2, 9'h133, 1'b0, '0);
    pix_req = 1'b0; cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
    #2 reset_N = 1'b0;
    #1 check_reset_state("midrst");
    repeat (2) @(posedge clock);
    #2 reset_N = 1'b1;
    model_clear();
    @(posedge clock); #1;
    idle(2);
    do_cycle(1'b1, 9'h0A1, 1'b0, '0, '0, 1'b0, '0);
    do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 9'h0A2);
    idle(4);

    // Randomised traffic over a small address window.
    for (int k = 0; k < 600; k++) begin
      bit pr;
      pr = !pix_prev && ($urandom_range(0, 1) == 1);
      do_cycle(pr, 9'h100 + 9'($urandom_range(0, 15)),
               $urandom_range(0, 9) < 4, 9'h100 + 9'($urandom_range(0, 15)), 9'($urandom),
               $urandom_range(0, 9) < 2, 9'h100 + 9'($urandom_range(0, 15)));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
